// File: rtl/btn_pkg.sv
// Shared types and defaults for the pushbutton / switch input conditioner.
// Holds the per-button FSM state encoding, default timing constants and a
// counter-width helper used by btn_debounce and btn_input_cond.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int unsigned DEF_DEBOUNCE   = 1_000_000;     // 10 ms at 100 MHz
    localparam int unsigned DEF_LONG_PRESS = 200_000_000;   // 2 s at 100 MHz
    localparam int unsigned SW_W           = 4;

    // Counter width for a terminal count of n; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/btn_input_cond_if.sv
// Bundle of raw user inputs and conditioned outputs.
//   master: drives raw btn0/btn1/sw, observes the conditioned outputs.
//   slave : the conditioner; consumes raw inputs, drives the outputs.
interface btn_input_cond_if;

    logic                     btn0;
    logic                     btn1;
    logic [btn_pkg::SW_W-1:0] sw;

    logic                     btn0_pulse;
    logic                     btn1_pulse;
    logic                     btn1_long;
    logic                     btn0_level;
    logic                     btn1_level;
    logic [btn_pkg::SW_W-1:0] sw_stable;
    logic                     sw_change;

    modport master (
        output btn0, btn1, sw,
        input  btn0_pulse, btn1_pulse, btn1_long, btn0_level, btn1_level,
        input  sw_stable, sw_change
    );

    modport slave (
        input  btn0, btn1, sw,
        output btn0_pulse, btn1_pulse, btn1_long, btn0_level, btn1_level,
        output sw_stable, sw_change
    );

endinterface

// File: rtl/btn_debounce.sv
// Single pushbutton conditioner: 2-flop synchronizer, debounce FSM,
// one-cycle press strobe and debounced level.
//   clk, reset_n : clock, async active-low reset
//   btn_raw_i    : raw asynchronous button
//   state_o      : registered FSM state (for hold timing in the parent)
//   pulse_o      : one-cycle strobe per accepted press
//   level_o      : 1 while HELD or RELEASE_WAIT
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_raw_i,
    output btn_state_t state_o,
    output logic       pulse_o,
    output logic       level_o
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             synced;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             enter_q, enter_d;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;

    assign synced = sync_q[1];

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            enter_q <= 1'b0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            enter_q <= enter_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    // Next state; the counter stops at CNT_LAST because the FSM leaves there.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        enter_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (synced) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!synced) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    enter_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!synced) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back high resumes HELD without a second strobe.
                if (synced) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Strobe lands the cycle after HELD entry.
        pulse_d = enter_q;
        level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    assign state_o = state_q;
    assign pulse_o = pulse_q;
    assign level_o = level_q;

endmodule

// File: rtl/btn_input_cond.sv
// Input conditioner for two pushbuttons and a 4-bit switch bank.
//   clk, reset_n     : clock, async active-low reset
//   bus.btn0/btn1/sw : raw asynchronous inputs
//   bus.btnX_pulse   : one-cycle strobe per accepted press
//   bus.btnX_level   : debounced button levels
//   bus.btn1_long    : one-cycle strobe after btn1 held LONG_PRESS_CYCLES
//   bus.sw_stable    : debounced switch value
//   bus.sw_change    : one-cycle strobe when sw_stable updates
module btn_input_cond
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE,
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS
) (
    input logic             clk,
    input logic             reset_n,
    btn_input_cond_if.slave bus
);

    localparam int unsigned       DB_W      = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned       HOLD_W    = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    btn_state_t b0_state_unused;
    btn_state_t b1_state;
    logic       b0_pulse, b0_level;
    logic       b1_pulse, b1_level;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_raw_i (bus.btn0),
        .state_o   (b0_state_unused),
        .pulse_o   (b0_pulse),
        .level_o   (b0_level)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_raw_i (bus.btn1),
        .state_o   (b1_state),
        .pulse_o   (b1_pulse),
        .level_o   (b1_level)
    );

    // ---------------- btn1 long press ----------------
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              fired_q, fired_d;
    logic              long_q, long_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            fired_q <= fired_d;
            long_q  <= long_d;
        end
    end

    // Count only in HELD, freeze through RELEASE_WAIT, clear once back in IDLE/PRESS_WAIT.
    always_comb begin
        hold_d  = hold_q;
        fired_d = fired_q;
        long_d  = 1'b0;
        case (b1_state)
            HELD: begin
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HOLD_W'(1);
                end else if (!fired_q) begin
                    long_d  = 1'b1;
                    fired_d = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                hold_d = hold_q;
            end
            default: begin
                hold_d  = '0;
                fired_d = 1'b0;
            end
        endcase
    end

    // ---------------- switch debounce ----------------
    logic [SW_W-1:0] sw_meta_q, sw_sync_q;
    logic [SW_W-1:0] sw_cand_q, sw_cand_d;
    logic [SW_W-1:0] sw_stable_q, sw_stable_d;
    logic [DB_W-1:0] sw_cnt_q, sw_cnt_d;
    logic            sw_change_q, sw_change_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            sw_cand_q   <= '0;
            sw_stable_q <= '0;
            sw_cnt_q    <= '0;
            sw_change_q <= 1'b0;
        end else begin
            sw_meta_q   <= bus.sw;
            sw_sync_q   <= sw_meta_q;
            sw_cand_q   <= sw_cand_d;
            sw_stable_q <= sw_stable_d;
            sw_cnt_q    <= sw_cnt_d;
            sw_change_q <= sw_change_d;
        end
    end

    // Any movement of the synced value restarts qualification of the new candidate.
    always_comb begin
        sw_cand_d   = sw_cand_q;
        sw_stable_d = sw_stable_q;
        sw_cnt_d    = sw_cnt_q;
        sw_change_d = 1'b0;
        if (sw_sync_q != sw_cand_q) begin
            sw_cand_d = sw_sync_q;
            sw_cnt_d  = '0;
        end else if (sw_cand_q != sw_stable_q) begin
            if (sw_cnt_q == DB_LAST) begin
                sw_stable_d = sw_cand_q;
                sw_change_d = 1'b1;
                sw_cnt_d    = '0;
            end else begin
                sw_cnt_d = sw_cnt_q + DB_W'(1);
            end
        end
    end

    assign bus.btn0_pulse = b0_pulse;
    assign bus.btn1_pulse = b1_pulse;
    assign bus.btn0_level = b0_level;
    assign bus.btn1_level = b1_level;
    assign bus.btn1_long  = long_q;
    assign bus.sw_stable  = sw_stable_q;
    assign bus.sw_change  = sw_change_q;

endmodule

// File: doc/btn_input_cond.md
BTN_INPUT_COND -- requirements
Module: btn_input_cond

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1_000_000, cycles a synchronized input must hold its new value before it is accepted (10 ms at 100 MHz).
REQ-002 Parameter: LONG_PRESS_CYCLES, default 200_000_000, cycles btn1 must stay debounced-high before btn1_long fires (2 s at 100 MHz).
REQ-003 clk  input  1  single system clock; all flops rising-edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 btn0  input  1  raw confirm pushbutton, asynchronous, bouncy.
REQ-006 btn1  input  1  raw exit/unlock pushbutton, asynchronous, bouncy.
REQ-007 sw  input  4  raw digit switches, asynchronous.
REQ-008 btn0_pulse  output  1  one-cycle strobe per accepted btn0 press.
REQ-009 btn1_pulse  output  1  one-cycle strobe per accepted btn1 press.
REQ-010 btn1_long  output  1  one-cycle strobe when btn1 held LONG_PRESS_CYCLES.
REQ-011 btn0_level, btn1_level  output  1 each  debounced button levels.
REQ-012 sw_stable  output  4  debounced switch value.
REQ-013 sw_change  output  1  one-cycle strobe when sw_stable updates.

Function
REQ-014 Every raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Each button SHALL use an FSM with states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-016 IDLE->PRESS_WAIT on synced=1. Counter cleared on entry.
REQ-017 PRESS_WAIT: counter +1 per cycle while synced=1. synced=0 returns to IDLE. Counter reaching DEBOUNCE_CYCLES-1 with synced=1 enters HELD.
REQ-018 HELD->RELEASE_WAIT on synced=0. RELEASE_WAIT->IDLE after DEBOUNCE_CYCLES consecutive synced=0 cycles. synced=1 during RELEASE_WAIT returns to HELD with no new pulse.
REQ-019 btnX_pulse SHALL be registered and high exactly one cycle, the cycle after entry to HELD. For a clean press, latency is DEBOUNCE_CYCLES+3 clocks from the first edge sampling raw=1.
REQ-020 btnX_level SHALL be 1 in HELD and RELEASE_WAIT, 0 otherwise.
REQ-021 btn1_long: a hold counter SHALL run while btn1 FSM is in HELD, starting at 0 on HELD entry. It fires once at LONG_PRESS_CYCLES-1 and saturates with no repeat until the FSM returns to IDLE. Bounce into RELEASE_WAIT and back SHALL NOT reset the hold counter.
REQ-022 btn0 and btn1 are independent: simultaneous presses SHALL produce both pulses in the same cycle.
REQ-023 sw: a new synced value differing from sw_stable starts a stability counter. Any change of the synced value restarts it. After DEBOUNCE_CYCLES unchanged cycles, sw_stable loads the value and sw_change pulses one cycle.
REQ-024 Counter widths SHALL be $clog2 of their parameter. Counters SHALL never wrap: saturate at terminal value.

Reset
REQ-025 reset_n=0 SHALL asynchronously force: FSMs to IDLE, all counters and synchronizers to 0, all pulse and level outputs to 0, and sw_stable to 4'h0.
REQ-026 Deassertion mid-press SHALL restart debounce from IDLE. No pulse SHALL be produced without a full DEBOUNCE_CYCLES qualification after reset release.

Structure
REQ-027 Shared package btn_pkg SHALL hold the FSM state typedef (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and default constants DEF_DEBOUNCE and DEF_LONG_PRESS.
REQ-028 Sub-module btn_debounce (synchronizer + FSM + pulse/level, parameterized) SHALL be instantiated once for btn0 and once for btn1. Long-press and switch logic stay in btn_input_cond.

Verification
Benches use DEBOUNCE_CYCLES=4 and LONG_PRESS_CYCLES=20.
REQ-029 Clean btn0 press held 10 cycles -> btn0_pulse high exactly 1 cycle at cycle 7 after the first high sample; btn0_level high until 4 cycles after release is synced.
REQ-030 btn1 glitch pattern 1,1,0,1,1,0 -> no btn1_pulse, btn1_level stays 0.
REQ-031 btn1 held 30 cycles -> one btn1_pulse, then one btn1_long 20 cycles after HELD entry, no repeat; a release-bounce of 2 low cycles inside the hold does not reset the long count.
REQ-032 btn0 and btn1 asserted on the same edge -> both pulses on the same cycle.
REQ-033 sw 0->5, bounce 5/4/5, then stable -> single sw_change, sw_stable=4'h5 four cycles after the last change.
REQ-034 reset_n pulsed low mid-PRESS_WAIT -> outputs 0 immediately (asynchronous); a press held through release yields a pulse at full latency counted from reset release.
